// File: rtl/deser_align_rx_if.sv
// Serial lane / aligned-word bundle for deser_align_rx.
// master drives the serial side; slave is the receiver.
interface deser_align_rx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             serial_in;
  logic             bit_en;
  logic             realign;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             is_com;
  logic             idle_det;
  logic             locked;
  logic [3:0]       com_cnt;

  modport master (
    output serial_in, bit_en, realign,
    input  data_out, data_valid, is_com, idle_det, locked, com_cnt
  );

  modport slave (
    input  serial_in, bit_en, realign,
    output data_out, data_valid, is_com, idle_det, locked, com_cnt
  );
endinterface

// File: rtl/deser_align_rx.sv
// Serial-to-parallel receiver that hunts for COM, aligns on it and flags IDLE/COM words.
// Define DESER_LSB_FIRST_EN to shift LSB-first instead of the default MSB-first.
module deser_align_rx #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] COM_SYM  = WIDTH'(8'hBC),
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(8'h7C),
  parameter int unsigned      COM_LOCK = 4,
  parameter int unsigned      MISS_MAX = 3
) (
  input logic             clk_1,
  input logic             reset,
  deser_align_rx_if.slave rx
);
  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [3:0]      ComLock = 4'(COM_LOCK);
  localparam logic [3:0]      MissMax = 4'(MISS_MAX);

  typedef enum logic [1:0] {StHunt, StAlign, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, data_q, data_d, nsr;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       com_cnt_q, com_cnt_d, miss_cnt_q, miss_cnt_d;
  logic             valid_q, valid_d;
  logic             boundary, nsr_com, complete;

`ifdef DESER_LSB_FIRST_EN
  assign nsr = {rx.serial_in, sr_q[WIDTH-1:1]};
`else
  assign nsr = {sr_q[WIDTH-2:0], rx.serial_in};
`endif

  assign boundary = (bit_cnt_q == LastBit);
  assign nsr_com  = (nsr == COM_SYM);
  // HUNT frames on the comma itself; once aligned, words frame on the bit counter.
  assign complete = (state_q == StHunt) ? nsr_com : boundary;

  always_ff @(posedge clk_1) begin
    if (reset) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_1) begin
    if (reset) begin
      sr_q       <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    com_cnt_d  = com_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = 1'b0;
    if (rx.realign) begin
      // The bit presented alongside realign is dropped: sr_q holds.
      state_d    = StHunt;
      bit_cnt_d  = '0;
      com_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (rx.bit_en) begin
      sr_d = nsr;
      if (complete) begin
        data_d    = nsr;
        valid_d   = 1'b1;
        bit_cnt_d = '0;
      end else if (!boundary) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      unique case (state_q)
        StHunt: begin
          if (nsr_com) begin
            com_cnt_d = 4'd1;
            state_d   = (ComLock == 4'd1) ? StLocked : StAlign;
          end
        end
        StAlign: begin
          if (complete) begin
            if (!nsr_com) begin
              com_cnt_d = '0;
              state_d   = StHunt;
            end else if (com_cnt_q + 4'd1 >= ComLock) begin
              com_cnt_d = ComLock;
              state_d   = StLocked;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end
        end
        StLocked: begin
          if (nsr_com) begin
            if (complete) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 4'd1 >= MissMax) begin
              state_d    = StHunt;
              com_cnt_d  = '0;
              miss_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    rx.data_out   = data_q;
    rx.data_valid = valid_q;
    rx.locked     = (state_q == StLocked);
    rx.is_com     = valid_q & (data_q == COM_SYM);
    rx.idle_det   = valid_q & (state_q == StLocked) & (data_q == IDLE_SYM);
    rx.com_cnt    = com_cnt_q;
  end
endmodule

// File: tb/tb_deser_align_rx.sv
// Bench for deser_align_rx: vector table plus hand sequences, with a cycle-stamped
// scoreboard of expected words checked whenever data_valid fires.
module tb_deser_align_rx;
  logic clk_1 = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk_1 = ~clk_1;

  deser_align_rx_if #(.WIDTH(8)) ifc ();

  deser_align_rx #(
    .WIDTH   (8),
    .COM_SYM (8'hBC),
    .IDLE_SYM(8'h7C),
    .COM_LOCK(4),
    .MISS_MAX(3)
  ) dut (
    .clk_1(clk_1),
    .reset(reset),
    .rx   (ifc)
  );

  typedef struct {
    logic [7:0] data;
    logic       is_com;
    logic       idle;
    logic       lk;
    logic [3:0] cc;
    int         at;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    logic       is_com;
    logic       idle;
    logic       lk;
    logic [3:0] cc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic i, input logic l,
                      input logic [3:0] cc, input int delta);
    exp_t e;
    e.data = d; e.is_com = c; e.idle = i; e.lk = l; e.cc = cc; e.at = cyc + delta;
    sb.push_back(e);
  endtask

  task automatic tick(input logic b, input logic en, input logic ra);
    ifc.serial_in = b;
    ifc.bit_en    = en;
    ifc.realign   = ra;
    @(posedge clk_1);
    cyc++;
    #1;
    ifc.realign = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) tick(w[i], 1'b1, 1'b0);
  endtask

  // Scoreboard: every data_valid must match the oldest expected word, on its cycle.
  always @(negedge clk_1) begin
    if (!reset) begin
      if (sb.size() != 0 && cyc > sb[0].at) begin
        chk("missed_valid_cycle", 32'(cyc), 32'(sb[0].at));
        void'(sb.pop_front());
      end
      if (ifc.data_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_sb_size", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(e.at));
          chk("data_out", 32'(ifc.data_out), 32'(e.data));
          chk("is_com", 32'(ifc.is_com), 32'(e.is_com));
          chk("idle_det", 32'(ifc.idle_det), 32'(e.idle));
          chk("locked", 32'(ifc.locked), 32'(e.lk));
          chk("com_cnt", 32'(ifc.com_cnt), 32'(e.cc));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{8'hBC, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[1] = '{8'hBC, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[2] = '{8'hBC, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[3] = '{8'hBC, 1'b1, 1'b0, 1'b1, 4'd4};
    vecs[4] = '{8'h7C, 1'b0, 1'b1, 1'b1, 4'd4};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b1, 4'd4};
    vecs[6] = '{8'hBC, 1'b1, 1'b0, 1'b1, 4'd4};

    ifc.serial_in = 1'b0;
    ifc.bit_en    = 1'b1;
    ifc.realign   = 1'b0;

    // Reset held 3 cycles while the lane toggles.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(i[0], 1'b1, 1'b0);
    chk("rst_data_out", 32'(ifc.data_out), 32'd0);
    chk("rst_data_valid", 32'(ifc.data_valid), 32'd0);
    chk("rst_is_com", 32'(ifc.is_com), 32'd0);
    chk("rst_idle_det", 32'(ifc.idle_det), 32'd0);
    chk("rst_locked", 32'(ifc.locked), 32'd0);
    chk("rst_com_cnt", 32'(ifc.com_cnt), 32'd0);
    reset = 1'b0;

    // Junk 101, then COM x4 to lock, then IDLE, data, COM while locked.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    for (int v = 0; v < 7; v++) begin
      push(vecs[v].word, vecs[v].is_com, vecs[v].idle, vecs[v].lk, vecs[v].cc, 8);
      send_word(vecs[v].word);
    end

    // Stream slipped by 3 bits: misaligned COMs at bits 11, 19, 27 drop lock.
    push(8'h17, 1'b0, 1'b0, 1'b1, 4'd4, 8);
    push(8'h97, 1'b0, 1'b0, 1'b1, 4'd4, 16);
    push(8'h97, 1'b0, 1'b0, 1'b1, 4'd4, 24);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(8'hBC);
    chk("miss_locked", 32'(ifc.locked), 32'd0);
    chk("miss_com_cnt", 32'(ifc.com_cnt), 32'd0);

    // Re-acquire, then a 5-cycle bit_en gap inside an ALIGN word.
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd1, 8);
    send_word(8'hBC);
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd2, 13);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(i[0], 1'b0, 1'b0);
    chk("gap_com_cnt", 32'(ifc.com_cnt), 32'd1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd3, 8);
    send_word(8'hBC);
    push(8'hBC, 1'b1, 1'b0, 1'b1, 4'd4, 8);
    send_word(8'hBC);
    chk("relock_locked", 32'(ifc.locked), 32'd1);

    // realign pulse while locked.
    tick(1'b1, 1'b1, 1'b1);
    chk("realign_locked", 32'(ifc.locked), 32'd0);
    chk("realign_com_cnt", 32'(ifc.com_cnt), 32'd0);
    chk("realign_valid", 32'(ifc.data_valid), 32'd0);

    // Two COMs then 0x00 in ALIGN returns to HUNT.
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd1, 8);
    send_word(8'hBC);
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd2, 8);
    send_word(8'hBC);
    push(8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8);
    send_word(8'h00);

    // IDLE seen during ALIGN must not raise idle_det.
    push(8'hBC, 1'b1, 1'b0, 1'b0, 4'd1, 8);
    send_word(8'hBC);
    push(8'h7C, 1'b0, 1'b0, 1'b0, 4'd0, 8);
    send_word(8'h7C);

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
